hazard_ctrl_sb: RTL
===================

// Module: hazard_ctrl_sb
// PURPOSE
//  Parametrised hazard/forwarding controller for the 5-stage RV32 pipeline, successor to the single-load-use stall detector.
//  Adds: configurable load-use depth, EX operand forwarding selects, a register scoreboard for the multi-cycle MDU,
//  branch flush arbitration, a saturating stall-cycle counter and a stall watchdog fault flag. Sits beside the ID/EX regs.
// PARAMETERS
//  NREG      32  architectural registers; index width RW = $clog2(NREG)
//  LOAD_LAT  1   load-use bubbles: 1 = check EX load only; 2 = also check MEM-stage load
//  WDT_LIMIT 64  consecutive stall cycles that set wdt_fault (>=2)
//  CNT_W     32  width of stall_count
// PORTS
//  clk           in  1     rising-edge clock
//  rst_n         in  1     async active-low reset
//  rs1_id/rs2_id in  RW    ID source regs;  rs1_used_id/rs2_used_id in 1: operand actually read
//  mdu_op_id     in  1     ID instruction is an MDU (mul/div) op
//  rs1_ex/rs2_ex in  RW    EX source regs (forwarding compare)
//  rd_ex         in  RW    EX dest; reg_write_ex in 1; mem_read_ex in 1; mdu_issue_ex in 1 (MDU op leaving EX this cycle)
//  rd_mem        in  RW    MEM dest; reg_write_mem in 1; mem_read_mem in 1
//  rd_wb         in  RW    WB dest; reg_write_wb in 1
//  mdu_done      in  1     MDU result written this cycle; mdu_rd in RW: its dest
//  branch_taken_ex in 1    taken branch/jump resolved in EX
//  fault_clear   in  1     clears wdt_fault
//  stall         out 1     hold PC and IF/ID, insert bubble into ID/EX
//  flush_id      out 1     squash IF/ID;  flush_ex out 1: squash ID/EX
//  fwd_a/fwd_b   out 2     00 regfile, 10 from MEM, 01 from WB
//  mdu_busy      out 1     an MDU op is outstanding
//  stall_count   out CNT_W saturating count of stall cycles
//  wdt_fault     out 1     sticky watchdog fault
// BEHAVIOUR
//  Reset (async, rst_n=0): scoreboard pend[]=0, mdu_busy=0, wdt counter=0, wdt_fault=0, stall_count=0.
//   Comb outputs follow inputs during reset except mdu_busy/pend-derived terms, which read 0.
//  Match(r,s) = used(s) && r==s && r!=0. Register x0 never stalls, forwards or is marked pending.
//  stall (combinational, same cycle) = !branch_taken_ex && (A || B || C || D):
//   A load-use EX: mem_read_ex && Match(rd_ex, rs1_id|rs2_id)
//   B (LOAD_LAT==2 only) mem_read_mem && Match(rd_mem, rs1_id|rs2_id)
//   C scoreboard: pend[rs1_id] or pend[rs2_id] for a used operand
//   D structural: mdu_op_id && mdu_busy && !mdu_done
//  Branch priority: branch_taken_ex=1 -> stall=0, flush_id=1, flush_ex=1 (stall and flush never both 1).
//   Else flush_ex=stall, flush_id=0.
//  Forwarding (EX operands): MEM wins over WB; fwd_a=10 if reg_write_mem && !mem_read_mem && rd_mem==rs1_ex!=0,
//   else 01 if reg_write_wb && rd_wb==rs1_ex!=0, else 00. fwd_b identical on rs2_ex.
//  Scoreboard (registered, visible next cycle):
//   mdu_issue_ex && reg_write_ex && rd_ex!=0 -> pend[rd_ex]<=1, mdu_busy<=1.
//   mdu_done -> pend[mdu_rd]<=0, mdu_busy<=0. Same cycle issue+done: clear applied first, set wins on same reg; busy stays 1.
//   mdu_issue_ex ignored while branch_taken_ex=1 (op squashed).
//  stall_count: +1 each cycle stall=1; saturates at all-ones, no wrap.
//  Watchdog: wcnt +1 per consecutive stall cycle, <=0 on any stall=0 cycle, saturates at WDT_LIMIT.
//   wcnt reaching WDT_LIMIT sets wdt_fault next edge; sticky until fault_clear=1 (clear wins over set same cycle) or reset.
// TESTING
//  1 lw x5 in EX, ID add x6,x5,x1 (rs1_used) -> stall=1, flush_ex=1 one cycle; rd_ex=0 or rs unused -> stall=0.
//  2 LOAD_LAT=2: mem_read_mem, rd_mem=7, rs2_id=7 -> stall=1; same with LOAD_LAT=1 -> stall=0.
//  3 div x9 issues; ID reads x9 -> stall until cycle after mdu_done,mdu_rd=9; issue+done same cycle on x9 -> pend[9] stays 1.
//  4 rd_mem=rd_wb=rs1_ex=3, both writing -> fwd_a=10; mem_read_mem=1 -> fwd_a=01; rs1_ex=0 -> 00.
//  5 stall pending + branch_taken_ex -> stall=0, flush_id=1, flush_ex=1; stall_count unchanged.
//  6 stall held 64 cycles (WDT_LIMIT=64) -> wdt_fault=1; drop stall -> stays 1; fault_clear -> 0; async reset mid-stall -> all 0.

Source files
------------

// File: rtl/hazard_ctrl_sb.sv
// Hazard and forwarding controller for the 5-stage RV32 pipeline: load-use and
// MDU scoreboard stalls, branch flush arbitration, EX forwarding, stall statistics and watchdog.
module hazard_ctrl_sb #(
    parameter int NREG      = 32,
    parameter int LOAD_LAT  = 1,
    parameter int WDT_LIMIT = 64,
    parameter int CNT_W     = 32,
    localparam int RW       = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RW-1:0]    rs1_id,
    input  logic [RW-1:0]    rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic             mdu_op_id,
    input  logic [RW-1:0]    rs1_ex,
    input  logic [RW-1:0]    rs2_ex,
    input  logic [RW-1:0]    rd_ex,
    input  logic             reg_write_ex,
    input  logic             mem_read_ex,
    input  logic             mdu_issue_ex,
    input  logic [RW-1:0]    rd_mem,
    input  logic             reg_write_mem,
    input  logic             mem_read_mem,
    input  logic [RW-1:0]    rd_wb,
    input  logic             reg_write_wb,
    input  logic             mdu_done,
    input  logic [RW-1:0]    mdu_rd,
    input  logic             branch_taken_ex,
    input  logic             fault_clear,
    output logic             stall,
    output logic             flush_id,
    output logic             flush_ex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_count,
    output logic             wdt_fault
);

    localparam int WW = $clog2(WDT_LIMIT + 1);
    localparam logic [WW-1:0] WDT_MAX = WW'(WDT_LIMIT);
    localparam logic [WW-1:0] WDT_PRE = WW'(WDT_LIMIT - 1);

    logic [NREG-1:0]  pend_r;
    logic [NREG-1:0]  pend_next_s;
    logic             mdu_busy_r;
    logic             mdu_issue_s;
    logic             hz_load_ex_s;
    logic             hz_load_mem_s;
    logic             hz_sb_s;
    logic             hz_struct_s;
    logic             stall_s;
    logic [WW-1:0]    wcnt_r;
    logic             wdt_fault_r;
    logic [CNT_W-1:0] stall_count_r;

    function automatic logic reg_match(input logic [RW-1:0] r, input logic [RW-1:0] s,
                                       input logic used);
        return used && (r == s) && (r != {RW{1'b0}});
    endfunction

    // MEM result has priority; a load in MEM has no data yet, so only WB can supply it
    function automatic logic [1:0] fwd_sel(input logic [RW-1:0] rs,
                                           input logic [RW-1:0] rdm, input logic wm, input logic lm,
                                           input logic [RW-1:0] rdw, input logic ww);
        return (wm && !lm && (rdm == rs) && (rs != {RW{1'b0}})) ? 2'b10 :
               (ww && (rdw == rs) && (rs != {RW{1'b0}}))        ? 2'b01 : 2'b00;
    endfunction

    // Hazard terms, stall/flush arbitration and scoreboard next state
    always_comb begin
        hz_load_ex_s  = mem_read_ex && (reg_match(rd_ex, rs1_id, rs1_used_id) ||
                                        reg_match(rd_ex, rs2_id, rs2_used_id));
        hz_load_mem_s = (LOAD_LAT == 2) && mem_read_mem &&
                        (reg_match(rd_mem, rs1_id, rs1_used_id) ||
                         reg_match(rd_mem, rs2_id, rs2_used_id));
        hz_sb_s       = (rs1_used_id && pend_r[rs1_id]) || (rs2_used_id && pend_r[rs2_id]);
        hz_struct_s   = mdu_op_id && mdu_busy_r && !mdu_done;
        stall_s       = !branch_taken_ex &&
                        (hz_load_ex_s || hz_load_mem_s || hz_sb_s || hz_struct_s);
        mdu_issue_s   = mdu_issue_ex && reg_write_ex && (rd_ex != {RW{1'b0}}) && !branch_taken_ex;
        // Clear is applied before set so a same-cycle reissue to the same register stays pending
        pend_next_s   = (pend_r & ~(mdu_done ? (NREG'(1) << mdu_rd) : {NREG{1'b0}})) |
                        (mdu_issue_s ? (NREG'(1) << rd_ex) : {NREG{1'b0}});
    end

    assign stall       = stall_s;
    assign flush_id    = branch_taken_ex;
    assign flush_ex    = branch_taken_ex | stall_s;
    assign fwd_a       = fwd_sel(rs1_ex, rd_mem, reg_write_mem, mem_read_mem, rd_wb, reg_write_wb);
    assign fwd_b       = fwd_sel(rs2_ex, rd_mem, reg_write_mem, mem_read_mem, rd_wb, reg_write_wb);
    assign mdu_busy    = mdu_busy_r;
    assign stall_count = stall_count_r;
    assign wdt_fault   = wdt_fault_r;

    // MDU destination scoreboard and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r     <= {NREG{1'b0}};
            mdu_busy_r <= 1'b0;
        end else begin
            pend_r     <= pend_next_s;
            mdu_busy_r <= mdu_issue_s ? 1'b1 : (mdu_done ? 1'b0 : mdu_busy_r);
        end
    end

    // Saturating stall-cycle statistic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_count_r != {CNT_W{1'b1}})) begin
            stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    // Watchdog: fault sets on the edge where the consecutive-stall run reaches the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_r      <= {WW{1'b0}};
            wdt_fault_r <= 1'b0;
        end else begin
            if (!stall_s) begin
                wcnt_r <= {WW{1'b0}};
            end else if (wcnt_r != WDT_MAX) begin
                wcnt_r <= wcnt_r + {{(WW-1){1'b0}}, 1'b1};
            end else begin
                wcnt_r <= wcnt_r;
            end
            if (fault_clear) begin
                wdt_fault_r <= 1'b0;
            end else if (stall_s && (wcnt_r >= WDT_PRE)) begin
                wdt_fault_r <= 1'b1;
            end else begin
                wdt_fault_r <= wdt_fault_r;
            end
        end
    end

endmodule
